// File: rtl/vga_timing_pkg.sv
// Shared constants for the VGA raster timing generator.
// Holds the default 640x480 @ 60 Hz timing, the coordinate width and the
// default sync polarity. No ports; imported by vga_axis_counter and
// vga_timing_gen.
package vga_timing_pkg;

   // Coordinate width. Either axis total must fit in this many bits.
   localparam int COORD_W = 11;

   // Largest axis total an 11-bit counter can represent.
   localparam int MAX_TOTAL = 1 << COORD_W;

   // Default 640x480 horizontal timing, in pixels.
   localparam int H_VISIBLE_DEFAULT = 640;
   localparam int H_FP_DEFAULT      = 16;
   localparam int H_SYNC_DEFAULT    = 96;
   localparam int H_BP_DEFAULT      = 48;

   // Default 640x480 vertical timing, in lines.
   localparam int V_VISIBLE_DEFAULT = 480;
   localparam int V_FP_DEFAULT      = 10;
   localparam int V_SYNC_DEFAULT    = 2;
   localparam int V_BP_DEFAULT      = 33;

   // Default 640x480 uses negative sync pulses.
   localparam logic SYNC_ACTIVE_DEFAULT = 1'b0;

   // Default clock divide: 100 MHz system clock down to a 25 MHz pixel rate.
   localparam int CLK_DIV_DEFAULT = 4;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a position counter with wrap detection plus sync and
// blank decode. It is instantiated once for the horizontal axis and once
// for the vertical axis.
// Ports:
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   advance  step the position by one on this clock edge
//   position current coordinate, 0..TOTAL-1 (registered)
//   wrap     high while position is at TOTAL-1 (combinational)
//   sync     sync level for the presented position (registered)
//   blank    high when the presented position is outside the visible area (registered)
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int   VISIBLE     = 640,
   parameter int   FP          = 16,
   parameter int   SYNC        = 96,
   parameter int   BP          = 48,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               advance,
   output logic [COORD_W-1:0] position,
   output logic               wrap,
   output logic               sync,
   output logic               blank
);

   localparam int TOTAL = VISIBLE + FP + SYNC + BP;

   localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
   localparam logic [COORD_W-1:0] VIS_END    = COORD_W'(VISIBLE);
   localparam logic [COORD_W-1:0] SYNC_START = COORD_W'(VISIBLE + FP);
   localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(VISIBLE + FP + SYNC);

   // Reject timings that would overflow the coordinate counter.
   if (TOTAL > MAX_TOTAL) begin : g_total_check
      $error("vga_axis_counter: axis total exceeds counter range");
   end

   logic [COORD_W-1:0] pos_next;

   assign wrap = (position == LAST);

   // Next position: step on advance and roll over after the last position.
   always_comb begin
      pos_next = position;
      if (advance) begin
         pos_next = wrap ? '0 : position + COORD_W'(1);
      end
   end

   // Sync and blank are decoded from the next position so that they line
   // up with the position register in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         position <= '0;
         sync     <= ~SYNC_ACTIVE;
         blank    <= 1'b0;
      end else begin
         position <= pos_next;
         sync     <= ((pos_next >= SYNC_START) && (pos_next < SYNC_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         blank    <= (pos_next >= VIS_END);
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. It divides the system clock down to a
// pixel-rate strobe, runs the horizontal and vertical position counters,
// and produces sync, blanking, pixel coordinates and a frame-start strobe.
// Every output is a flop, and all of them describe the same raster position.
// Ports:
//   CLK_100MHz  system clock
//   Reset       asynchronous active-low reset
//   HS, VS      horizontal / vertical sync, SYNC_ACTIVE during the pulse
//   HBlank      high when CurrentX >= H_VISIBLE
//   VBlank      high when CurrentY >= V_VISIBLE
//   CurrentX    horizontal position, 0..H_TOTAL-1
//   CurrentY    vertical position, 0..V_TOTAL-1
//   PixelEn     one-clock strobe, once per pixel period
//   FrameStart  one-clock strobe when the position wraps to (0,0)
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   CLK_DIV     = CLK_DIV_DEFAULT,
   parameter int   H_VISIBLE   = H_VISIBLE_DEFAULT,
   parameter int   H_FP        = H_FP_DEFAULT,
   parameter int   H_SYNC      = H_SYNC_DEFAULT,
   parameter int   H_BP        = H_BP_DEFAULT,
   parameter int   V_VISIBLE   = V_VISIBLE_DEFAULT,
   parameter int   V_FP        = V_FP_DEFAULT,
   parameter int   V_SYNC      = V_SYNC_DEFAULT,
   parameter int   V_BP        = V_BP_DEFAULT,
   parameter logic SYNC_ACTIVE = SYNC_ACTIVE_DEFAULT
) (
   input  logic               CLK_100MHz,
   input  logic               Reset,
   output logic               HS,
   output logic               VS,
   output logic               HBlank,
   output logic               VBlank,
   output logic [COORD_W-1:0] CurrentX,
   output logic [COORD_W-1:0] CurrentY,
   output logic               PixelEn,
   output logic               FrameStart
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   // A divide of 1 would leave no idle clocks between pixel strobes.
   if (CLK_DIV < 2) begin : g_div_check
      $error("vga_timing_gen: CLK_DIV must be at least 2");
   end

   logic [DIV_W-1:0] div_count;
   logic [DIV_W-1:0] div_next;
   logic             h_wrap;
   logic             v_wrap;

   assign div_next = (div_count == DIV_LAST) ? '0 : div_count + DIV_W'(1);

   // PixelEn is registered from the next divider value, so it is high
   // during the cycle in which the divider sits at its last count. The
   // counters step on the edge that closes that cycle. FrameStart is raised
   // on the edge where both axes wrap together, so it lines up with the
   // first cycle of (0,0). Reset entry never raises it.
   always_ff @(posedge CLK_100MHz or negedge Reset) begin
      if (!Reset) begin
         div_count  <= '0;
         PixelEn    <= 1'b0;
         FrameStart <= 1'b0;
      end else begin
         div_count  <= div_next;
         PixelEn    <= (div_next == DIV_LAST);
         FrameStart <= PixelEn & h_wrap & v_wrap;
      end
   end

   vga_axis_counter #(
      .VISIBLE    (H_VISIBLE),
      .FP         (H_FP),
      .SYNC       (H_SYNC),
      .BP         (H_BP),
      .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_h_axis (
      .clk     (CLK_100MHz),
      .rst_n   (Reset),
      .advance (PixelEn),
      .position(CurrentX),
      .wrap    (h_wrap),
      .sync    (HS),
      .blank   (HBlank)
   );

   // The vertical axis only moves on the pixel strobe that ends a line.
   vga_axis_counter #(
      .VISIBLE    (V_VISIBLE),
      .FP         (V_FP),
      .SYNC       (V_SYNC),
      .BP         (V_BP),
      .SYNC_ACTIVE(SYNC_ACTIVE)
   ) u_v_axis (
      .clk     (CLK_100MHz),
      .rst_n   (Reset),
      .advance (PixelEn & h_wrap),
      .position(CurrentY),
      .wrap    (v_wrap),
      .sync    (VS),
      .blank   (VBlank)
   );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Three instances share one clock and one
// reset:
//   dut0  default 640x480 timing
//   dut1  800x600 timing, CLK_DIV=2, SYNC_ACTIVE=1
//   dut2  tiny raster, so that many whole frames fit in a short run
// The expected outputs of every instance are computed from the number of
// clock edges since reset release, using plain arithmetic.
module tb_vga_timing_gen;

   localparam int   NUM_DUT = 3;
   localparam int   DIV_P [NUM_DUT] = '{4, 2, 3};
   localparam int   HV_P  [NUM_DUT] = '{640, 800, 10};
   localparam int   HFP_P [NUM_DUT] = '{16, 40, 2};
   localparam int   HS_P  [NUM_DUT] = '{96, 128, 3};
   localparam int   HBP_P [NUM_DUT] = '{48, 88, 2};
   localparam int   VV_P  [NUM_DUT] = '{480, 600, 6};
   localparam int   VFP_P [NUM_DUT] = '{10, 1, 1};
   localparam int   VS_P  [NUM_DUT] = '{2, 4, 2};
   localparam int   VBP_P [NUM_DUT] = '{33, 23, 1};
   localparam logic SA_P  [NUM_DUT] = '{1'b0, 1'b1, 1'b0};

   logic clk;
   logic reset_n;
   logic [27:0] observed [NUM_DUT];

   int checks;
   int errors;
   int edge_count;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
      logic        hs, vs, hblank, vblank, pixel_en, frame_start;
      logic [10:0] cur_x, cur_y;

      vga_timing_gen #(
         .CLK_DIV    (DIV_P[g]),
         .H_VISIBLE  (HV_P[g]),
         .H_FP       (HFP_P[g]),
         .H_SYNC     (HS_P[g]),
         .H_BP       (HBP_P[g]),
         .V_VISIBLE  (VV_P[g]),
         .V_FP       (VFP_P[g]),
         .V_SYNC     (VS_P[g]),
         .V_BP       (VBP_P[g]),
         .SYNC_ACTIVE(SA_P[g])
      ) dut (
         .CLK_100MHz(clk),
         .Reset     (reset_n),
         .HS        (hs),
         .VS        (vs),
         .HBlank    (hblank),
         .VBlank    (vblank),
         .CurrentX  (cur_x),
         .CurrentY  (cur_y),
         .PixelEn   (pixel_en),
         .FrameStart(frame_start)
      );

      assign observed[g] = {hs, vs, hblank, vblank, pixel_en, frame_start, cur_x, cur_y};
   end

   // Reference: after k clock edges since release, the pixel index is
   // k / CLK_DIV, and the raster position follows from that index.
   // Packed as {HS, VS, HBlank, VBlank, PixelEn, FrameStart, X, Y}.
   function automatic logic [27:0] modelOut(input int g, input int k);
      int   d, ht, vt, p, x, y;
      logic hs, vs, hb, vb, pe, fs;
      d  = DIV_P[g];
      ht = HV_P[g] + HFP_P[g] + HS_P[g] + HBP_P[g];
      vt = VV_P[g] + VFP_P[g] + VS_P[g] + VBP_P[g];
      p  = k / d;
      x  = p % ht;
      y  = (p / ht) % vt;
      hs = (x >= HV_P[g] + HFP_P[g] && x < HV_P[g] + HFP_P[g] + HS_P[g]) ? SA_P[g] : !SA_P[g];
      vs = (y >= VV_P[g] + VFP_P[g] && y < VV_P[g] + VFP_P[g] + VS_P[g]) ? SA_P[g] : !SA_P[g];
      hb = (x >= HV_P[g]);
      vb = (y >= VV_P[g]);
      pe = ((k % d) == d - 1);
      fs = (k > 0) && ((k % d) == 0) && ((p % (ht * vt)) == 0);
      return {hs, vs, hb, vb, pe, fs, 11'(x), 11'(y)};
   endfunction

   task automatic checkOutput(input string tag, input logic [27:0] actual, input logic [27:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got hs/vs/hb/vb/pe/fs=%b x=%0d y=%0d, expected hs/vs/hb/vb/pe/fs=%b x=%0d y=%0d",
                  tag, actual[27:22], actual[21:11], actual[10:0],
                  expected[27:22], expected[21:11], expected[10:0]);
      end
   endtask

   task automatic checkAll(input string phase);
      for (int i = 0; i < NUM_DUT; i++) begin
         checkOutput($sformatf("%s dut%0d k=%0d", phase, i, edge_count), observed[i], modelOut(i, edge_count));
      end
   endtask

   // Release reset at a falling edge, then run and check for the given
   // number of clocks.
   task automatic applyStimulus(input int run_cycles);
      reset_n = 1'b1;
      edge_count = 0;
      repeat (run_cycles) begin
         @(posedge clk);
         edge_count++;
         @(negedge clk);
         checkAll("run");
      end
   endtask

   // Assert reset between clock edges. The outputs must be back at their
   // reset values before the next rising edge. Reset is then held for a few
   // clocks.
   task automatic pulseReset(input int hold_cycles);
      #($urandom_range(1, 3));
      reset_n = 1'b0;
      edge_count = 0;
      #1;
      checkAll("async-reset");
      repeat (hold_cycles) begin
         @(negedge clk);
         checkAll("in-reset");
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_count = 0;
      reset_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkAll("power-on");
      end
      // The first run covers more than two default lines: the 3200-clock
      // line period, hsync at 656..751 and hblank at 640..799. It also
      // covers several dut1 lines (hsync at 840..967) and many dut2 frames.
      applyStimulus(7000);
      for (int seg = 0; seg < 7; seg++) begin
         pulseReset($urandom_range(1, 5));
         @(negedge clk);
         applyStimulus($urandom_range(300, 2500));
      end
      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
